// File: rtl/key_loader.sv
// key_loader
// ----------
// Collects key bytes from the bitstream parser into a KEY_LENGTH-bit shift
// register. Once the last byte has arrived, it writes the assembled key to
// key storage with a single strobe.
//
// Load sequence:
// - load_start opens a load.
// - Bytes are taken on byte_valid & byte_ready.
// - The first byte lands in the most significant byte.
// - After KEY_LENGTH/8 bytes the key is committed for one cycle, then
//   load_done pulses.
// - abort, or TIMEOUT_CYCLES consecutive cycles without a byte, drops the
//   partial key and pulses load_err.
//
// Build option:
//   KEY_LOADER_LOCK_EN  When defined, a completed load parks the FSM in
//                       LOCKED. A later load_start is then rejected with a
//                       load_err pulse. Only reset leaves LOCKED.
//                       When undefined, reloads are unlimited.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   load_start  in   request to begin a key load
//   abort       in   cancel an in-progress load
//   byte_valid  in   byte_data carries a key byte
//   byte_data   in   [7:0] key byte
//   byte_ready  out  loader accepts a byte this cycle (LOAD only)
//   key_write   out  one-cycle write strobe to key storage
//   key_data    out  [KEY_LENGTH-1:0] assembled key, zero outside COMMIT
//   busy        out  high in LOAD and COMMIT
//   load_done   out  one-cycle pulse after a successful commit
//   load_err    out  one-cycle pulse on abort, timeout or rejected start
module key_loader #(
  parameter int KEY_LENGTH     = 128,  // must be a multiple of 8
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  key_write,
  output logic [KEY_LENGTH-1:0] key_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int NBYTES = KEY_LENGTH / 8;
  localparam int BCNT_W = $clog2(NBYTES) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COMMIT = 3'd2,
    S_DONE   = 3'd3
`ifdef KEY_LOADER_LOCK_EN
    , S_LOCKED = 3'd4
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [KEY_LENGTH-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  err_q, err_d;

  logic accept;
  logic timeout;

  assign accept = (state_q == S_LOAD) && byte_valid;

  // The idle counter holds the number of idle cycles already elapsed. The
  // cycle that would make it reach TIMEOUT_CYCLES is the expiring one, and
  // it aborts the load exactly like an external abort.
  assign timeout = (state_q == S_LOAD) && !byte_valid && (tcnt_q == TCNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          shift_d = '0;
          bcnt_d  = '0;
          tcnt_d  = '0;
        end
      end

      S_LOAD: begin
        // abort outranks a byte arriving in the same cycle, including the
        // final byte: the byte is dropped and nothing is committed.
        if (abort || timeout) begin
          state_d = S_IDLE;
          shift_d = '0;
          bcnt_d  = '0;
          tcnt_d  = '0;
          err_d   = 1'b1;
        end else if (accept) begin
          shift_d = (shift_q << 8) | KEY_LENGTH'(byte_data);
          bcnt_d  = bcnt_q + BCNT_W'(1);
          tcnt_d  = '0;
          if (bcnt_q == LAST_BYTE) begin
            state_d = S_COMMIT;
          end
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      S_COMMIT: begin
        state_d = S_DONE;
        shift_d = '0;
        bcnt_d  = '0;
      end

      S_DONE: begin
`ifdef KEY_LOADER_LOCK_EN
        state_d = S_LOCKED;
`else
        state_d = S_IDLE;
`endif
      end

`ifdef KEY_LOADER_LOCK_EN
      S_LOCKED: begin
        if (load_start) begin
          err_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign byte_ready = (state_q == S_LOAD);
  assign key_write  = (state_q == S_COMMIT);
  assign busy       = (state_q == S_LOAD) || (state_q == S_COMMIT);
  assign load_done  = (state_q == S_DONE);
  assign load_err   = err_q;

  // Storage only ever sees the key while it is being written. Each byte
  // lane is gated by the write strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_key_lane
      assign key_data[gi*8 +: 8] = key_write ? shift_q[gi*8 +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: KEY_LENGTH=128, TIMEOUT_CYCLES=8.
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.
module tb_key_loader;

  localparam int KL = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic          abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          key_write;
  logic [KL-1:0] key_data;
  logic          busy;
  logic          load_done;
  logic          load_err;

  int n_checks = 0;
  int n_errors = 0;

  // Event counters observed at the clock edge.
  int            kw_count  = 0;
  int            acc_count = 0;
  logic [KL-1:0] kw_data   = '0;

  key_loader #(.KEY_LENGTH(KL), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .abort     (abort),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .key_write (key_write),
    .key_data  (key_data),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_write) begin
      kw_count <= kw_count + 1;
      kw_data  <= key_data;
    end
    if (byte_valid && byte_ready) acc_count <= acc_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (byte_ready !== 1'b0) begin n_errors++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    n_checks++; if (key_write !== 1'b0) begin n_errors++; $display("FAIL reset_key_write: got %b want 0", key_write); end
    n_checks++; if (key_data !== '0) begin n_errors++; $display("FAIL reset_key_data: got %h want 0", key_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (load_done !== 1'b0) begin n_errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    n_checks++; if (load_err !== 1'b0) begin n_errors++; $display("FAIL reset_load_err: got %b want 0", load_err); end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    logic [KL-1:0] exp_key;
    int base;
    exp_key = 128'h000102030405060708090A0B0C0D0E0F;
    base = kw_count;
    start_load();
    n_checks++; if (byte_ready !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL b2b_load_state: got ready=%b busy=%b want 1 1", byte_ready, busy); end
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(i);
      tick();
    end
    byte_valid = 1'b0;
    n_checks++; if (key_write !== 1'b1) begin n_errors++; $display("FAIL b2b_key_write: got %b want 1", key_write); end
    n_checks++; if (key_data !== exp_key) begin n_errors++; $display("FAIL b2b_key_data: got %h want %h", key_data, exp_key); end
    n_checks++; if (byte_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_commit_ready: got %b want 0", byte_ready); end
    tick();
    n_checks++; if (load_done !== 1'b1 || key_write !== 1'b0) begin n_errors++; $display("FAIL b2b_done: got done=%b kw=%b want 1 0", load_done, key_write); end
    n_checks++; if (key_data !== '0) begin n_errors++; $display("FAIL b2b_key_cleared: got %h want 0", key_data); end
    tick();
    n_checks++; if (load_done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", load_done, busy); end
    n_checks++; if (kw_count - base !== 1) begin n_errors++; $display("FAIL b2b_write_count: got %0d want 1", kw_count - base); end
    $display("test_back_to_back done");
  endtask

  task automatic test_toggle_valid();
    int base_kw;
    int base_acc;
    base_kw  = kw_count;
    base_acc = acc_count;
    start_load();
    byte_data = 8'hA5;
    // The 16th accepted byte falls in cycle 30. The remaining cycles keep
    // toggling valid while the loader is no longer ready.
    for (int c = 0; c < 36; c++) begin
      byte_valid = (c % 2 == 0);
      tick();
    end
    byte_valid = 1'b0;
    n_checks++; if (acc_count - base_acc !== 16) begin n_errors++; $display("FAIL toggle_accepts: got %0d want 16", acc_count - base_acc); end
    n_checks++; if (kw_count - base_kw !== 1) begin n_errors++; $display("FAIL toggle_write_count: got %0d want 1", kw_count - base_kw); end
    n_checks++; if (kw_data !== {16{8'hA5}}) begin n_errors++; $display("FAIL toggle_key_data: got %h want %h", kw_data, {16{8'hA5}}); end
    $display("test_toggle_valid done");
  endtask

  task automatic test_abort_last();
    int base;
    base = kw_count;
    start_load();
    for (int i = 0; i < 15; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'h30 + i);
      tick();
    end
    abort     = 1'b1;
    byte_data = 8'h3F;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    n_checks++; if (load_err !== 1'b1) begin n_errors++; $display("FAIL abort_err_pulse: got %b want 1", load_err); end
    n_checks++; if (busy !== 1'b0 || byte_ready !== 1'b0 || key_write !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got busy=%b ready=%b kw=%b want 0 0 0", busy, byte_ready, key_write); end
    tick();
    n_checks++; if (load_err !== 1'b0) begin n_errors++; $display("FAIL abort_err_one_cycle: got %b want 0", load_err); end
    tick();
    tick();
    n_checks++; if (kw_count - base !== 0) begin n_errors++; $display("FAIL abort_no_write: got %0d want 0", kw_count - base); end
    $display("test_abort_last done");
  endtask

  task automatic test_timeout();
    int base;
    logic early;
    base  = kw_count;
    early = 1'b0;
    start_load();
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'h50 + i);
      tick();
    end
    byte_valid = 1'b0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (load_err !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_errors++; $display("FAIL timeout_early: got early=%b want 0", early); end
    tick();
    n_checks++; if (load_err !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL timeout_err: got err=%b busy=%b want 1 0", load_err, busy); end
    tick();
    n_checks++; if (kw_count - base !== 0) begin n_errors++; $display("FAIL timeout_no_write: got %0d want 0", kw_count - base); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_midload();
    int base;
    base = kw_count;
    start_load();
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      tick();
    end
    byte_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin n_errors++; $display("FAIL midreset_idle: got busy=%b ready=%b want 0 0", busy, byte_ready); end
    start_load();
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      tick();
    end
    byte_valid = 1'b0;
    n_checks++; if (key_write !== 1'b1 || key_data !== {KL{1'b1}}) begin n_errors++; $display("FAIL midreset_key: got kw=%b data=%h want 1 all-ff", key_write, key_data); end
    tick();
    tick();
    n_checks++; if (kw_count - base !== 1) begin n_errors++; $display("FAIL midreset_write_count: got %0d want 1", kw_count - base); end
    $display("test_reset_midload done");
  endtask

  task automatic test_reload();
    int base;
    logic [KL-1:0] exp_key;
    base = kw_count;
    for (int i = 0; i < 16; i++) exp_key[KL-1-8*i -: 8] = 8'(8'hF0 - i);
    start_load();
`ifdef KEY_LOADER_LOCK_EN
    n_checks++; if (load_err !== 1'b1 || byte_ready !== 1'b0) begin n_errors++; $display("FAIL reload_locked: got err=%b ready=%b want 1 0", load_err, byte_ready); end
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'hF0 - i);
      tick();
    end
    byte_valid = 1'b0;
    tick();
    n_checks++; if (kw_count - base !== 0 || byte_ready !== 1'b0) begin n_errors++; $display("FAIL reload_locked_no_write: got writes=%0d ready=%b want 0 0", kw_count - base, byte_ready); end
`else
    n_checks++; if (byte_ready !== 1'b1 || load_err !== 1'b0) begin n_errors++; $display("FAIL reload_start: got ready=%b err=%b want 1 0", byte_ready, load_err); end
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'hF0 - i);
      tick();
    end
    byte_valid = 1'b0;
    n_checks++; if (key_write !== 1'b1 || key_data !== exp_key) begin n_errors++; $display("FAIL reload_key: got kw=%b data=%h want 1 %h", key_write, key_data, exp_key); end
    tick();
    n_checks++; if (load_done !== 1'b1) begin n_errors++; $display("FAIL reload_done: got %b want 1", load_done); end
`endif
    $display("test_reload done");
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_abort_last();
    test_timeout();
    test_reset_midload();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 SHALL have parameter KEY_LENGTH: default 128; key width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES: default 1024; maximum idle cycles between accepted bytes while loading.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port load_start, input, 1 bit: request to begin a key load.
REQ-006 SHALL have port abort, input, 1 bit: cancels an in-progress load.
REQ-007 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid key byte.
REQ-008 SHALL have port byte_data, input, 8 bits: key byte from the bitstream parser.
REQ-009 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 SHALL have port key_write, output, 1 bit: one-cycle write strobe to key storage.
REQ-011 SHALL have port key_data, output, KEY_LENGTH bits: assembled key to key storage.
REQ-012 SHALL have port busy, output, 1 bit: high in LOAD and COMMIT.
REQ-013 SHALL have port load_done, output, 1 bit: one-cycle pulse after a successful commit.
REQ-014 SHALL have port load_err, output, 1 bit: one-cycle pulse on abort, timeout or rejected start.

Function
REQ-015 SHALL implement the states IDLE, LOAD, COMMIT and DONE, plus LOCKED when REQ-031 applies.
REQ-016 In IDLE, a sampled load_start=1 SHALL move the FSM to LOAD next cycle and clear the shift register, byte counter and timeout counter.
REQ-017 In LOAD, byte_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 A byte SHALL be accepted only when byte_valid=1 and byte_ready=1 in the same cycle.
REQ-019 On each accepted byte the shift register SHALL shift left 8 bits and insert byte_data at bits [7:0], so the first byte ends up in bits [KEY_LENGTH-1:KEY_LENGTH-8].
REQ-020 Acceptance of byte number KEY_LENGTH/8 SHALL move the FSM to COMMIT next cycle.
REQ-021 In COMMIT, key_write SHALL be 1 for exactly one cycle with key_data equal to the assembled key; the FSM SHALL then move to DONE.
REQ-022 key_data SHALL be all-zero in every cycle except COMMIT.
REQ-023 The shift register SHALL be cleared on leaving COMMIT.
REQ-024 In DONE, load_done SHALL be 1 for one cycle; the FSM SHALL then move to IDLE (or to LOCKED per REQ-031).
REQ-025 In LOAD, abort=1 SHALL move the FSM to IDLE next cycle, pulse load_err, clear the shift register and produce no key_write.
REQ-026 When abort=1 coincides with byte acceptance or the final byte, abort SHALL take priority; the byte SHALL be discarded and there SHALL be no COMMIT.
REQ-027 The timeout counter SHALL increment each LOAD cycle with no accepted byte and reset on each acceptance; on reaching TIMEOUT_CYCLES it SHALL behave as abort.
REQ-028 load_start SHALL be ignored in LOAD, COMMIT and DONE, and abort SHALL be ignored outside LOAD.
REQ-029 The byte counter width SHALL be clog2(KEY_LENGTH/8)+1 and SHALL never wrap in a legal flow.

Reset
REQ-030 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE (LOCKED is also exited), all counters and the shift register SHALL clear, and byte_ready, key_write, key_data, busy, load_done and load_err SHALL be 0 the next cycle; a load interrupted by reset SHALL produce no key_write.

Configuration
REQ-031 With macro KEY_LOADER_LOCK_EN defined, DONE SHALL go to LOCKED; in LOCKED, load_start=1 SHALL pulse load_err and SHALL NOT start a load; only reset SHALL leave LOCKED.
REQ-032 Without KEY_LOADER_LOCK_EN, DONE SHALL return to IDLE, unlimited reloads SHALL be allowed, and the LOCKED state SHALL NOT exist.

Verification
REQ-033 Scenario: load_start, then 16 back-to-back bytes 0x00..0x0F -> single key_write with key_data=0x000102030405060708090A0B0C0D0E0F, load_done one cycle later, key_data=0 afterward.
REQ-034 Scenario: 16 bytes 0xA5 with byte_valid toggled every other cycle -> 16 acceptances only, key_data=all 0xA5 at key_write.
REQ-035 Scenario: abort asserted together with the 16th byte -> no key_write, load_err pulse, FSM in IDLE, busy=0.
REQ-036 Scenario: TIMEOUT_CYCLES=8 and a stall after byte 5 -> load_err pulse 8 cycles after the last acceptance, no key_write.
REQ-037 Scenario: rst_n=0 after byte 10, then a fresh full load of 0xFF bytes -> key_data=all 0xFF with no residue from the earlier bytes.
REQ-038 Scenario: with KEY_LOADER_LOCK_EN, a second load_start after a completed load -> load_err pulse, byte_ready stays 0, no key_write; without the macro -> second load completes normally.
